// File: rtl/rotate_pkg.sv
// Shared types and the single-step rotate helper for the rotate amount finder.
package rotate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Widest word rot1 supports; callers zero-extend into this and pass their real width.
  localparam int ROT_MAX_W = 64;
  localparam logic [ROT_MAX_W-1:0] ROT_ONE = {{(ROT_MAX_W-1){1'b0}}, 1'b1};

  // Rotate the low 'width' bits of word by one position; bits above width return zero.
  function automatic logic [ROT_MAX_W-1:0] rot1(input logic [ROT_MAX_W-1:0] word,
                                                input int unsigned         width,
                                                input logic                dir);
    logic [ROT_MAX_W-1:0] mask;
    logic [ROT_MAX_W-1:0] w;
    logic [ROT_MAX_W-1:0] res;
    mask = (ROT_ONE << width) - ROT_ONE;
    w    = word & mask;
    if (dir == DIR_RIGHT) begin
      res = ((w >> 1) | ((w & ROT_ONE) << (width - 32'd1))) & mask;
    end else begin
      res = ((w << 1) | (w >> (width - 32'd1))) & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/rotate_step.sv
// Combinational one-position rotate of a W-bit word in the requested direction.
module rotate_step
  import rotate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] word,
  input  logic         dir,
  output logic [W-1:0] stepped
);

  logic [ROT_MAX_W-1:0] wide_s;

  assign wide_s  = rot1(ROT_MAX_W'(word), W, dir);
  assign stepped = wide_s[W-1:0];

endmodule

// File: rtl/rotate_amount_finder.sv
// Finds the smallest rotate amount mapping orig onto rot, one candidate per clock,
// and flags periodic words where a second, larger amount also matches.
module rotate_amount_finder
  import rotate_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [(2**N)-1:0]   orig,
  input  logic [(2**N)-1:0]   rot,
  input  logic                dir,
  output logic                done_valid,
  input  logic                done_ready,
  output logic [N-1:0]        amt,
  output logic                found,
  output logic                multi
);

  localparam int W = 2**N;
  localparam logic [N-1:0] CAND_LAST = {N{1'b1}};
  localparam logic [N-1:0] CAND_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t         state_r, state_s;
  logic [W-1:0]   work_r, work_s;
  logic [W-1:0]   target_r, target_s;
  logic           dir_r, dir_s;
  logic [N-1:0]   cand_r, cand_s;
  logic [N-1:0]   amt_r, amt_s;
  logic           found_r, found_s;
  logic           multi_r, multi_s;
  logic [W-1:0]   work_step_s;
  logic           match_s;

  rotate_step #(.W(W)) u_step (
    .word    (work_r),
    .dir     (dir_r),
    .stepped (work_step_s)
  );

  assign match_s = (work_r == target_r);

  // Next-state and next-value logic for the search FSM.
  always_comb begin
    state_s  = state_r;
    work_s   = work_r;
    target_s = target_r;
    dir_s    = dir_r;
    cand_s   = cand_r;
    amt_s    = amt_r;
    found_s  = found_r;
    multi_s  = multi_r;
    case (state_r)
      IDLE: begin
        if (start_valid) begin
          work_s   = orig;
          target_s = rot;
          dir_s    = dir;
          cand_s   = {N{1'b0}};
          amt_s    = {N{1'b0}};
          found_s  = 1'b0;
          multi_s  = 1'b0;
          state_s  = SEARCH;
        end else begin
          state_s  = IDLE;
        end
      end
      SEARCH: begin
        if (match_s && found_r) begin
          // Second hit means the word is periodic; nothing more to learn.
          multi_s = 1'b1;
          state_s = DONE;
        end else begin
          if (match_s) begin
            amt_s   = cand_r;
            found_s = 1'b1;
          end else begin
            found_s = found_r;
          end
          if (cand_r == CAND_LAST) begin
            state_s = DONE;
          end else begin
            work_s  = work_step_s;
            cand_s  = cand_r + CAND_ONE;
          end
        end
      end
      DONE: begin
        if (done_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      work_r   <= {W{1'b0}};
      target_r <= {W{1'b0}};
      dir_r    <= DIR_RIGHT;
      cand_r   <= {N{1'b0}};
      amt_r    <= {N{1'b0}};
      found_r  <= 1'b0;
      multi_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      work_r   <= work_s;
      target_r <= target_s;
      dir_r    <= dir_s;
      cand_r   <= cand_s;
      amt_r    <= amt_s;
      found_r  <= found_s;
      multi_r  <= multi_s;
    end
  end

  assign start_ready = (state_r == IDLE);
  assign done_valid  = (state_r == DONE);
  assign amt         = amt_r;
  assign found       = found_r;
  assign multi       = multi_r;

endmodule

// File: tb/tb_rotate_amount_finder.sv
// Self-checking bench for rotate_amount_finder (N=3) against a rotation-table model.
module tb_rotate_amount_finder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] orig;
  logic [7:0] rot;
  logic       dir;
  logic       done_valid;
  logic       done_ready;
  logic [2:0] amt;
  logic       found;
  logic       multi;

  int passed = 0;
  int total  = 0;

  rotate_amount_finder #(.N(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .orig        (orig),
    .rot         (rot),
    .dir         (dir),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .amt         (amt),
    .found       (found),
    .multi       (multi)
  );

  always #5 clk = ~clk;

  // Rotate x by k positions; a left rotation by k equals a right rotation by 8-k.
  function automatic logic [7:0] rot_ref(input logic [7:0] x, input int k, input logic d);
    int s;
    logic [15:0] dbl;
    s   = d ? (8 - k) % 8 : k % 8;
    dbl = {x, x} >> s;
    return dbl[7:0];
  endfunction

  // Expected result: list every matching amount, then read off first/second hit.
  task automatic model(input logic [7:0] o, input logic [7:0] r, input logic d,
                       output int e_amt, output int e_found, output int e_multi, output int e_lat);
    int hits[$];
    for (int k = 0; k < 8; k++) begin
      if (rot_ref(o, k, d) == r) hits.push_back(k);
    end
    e_found = (hits.size() > 0) ? 1 : 0;
    e_amt   = (hits.size() > 0) ? hits[0] : 0;
    e_multi = (hits.size() > 1) ? 1 : 0;
    e_lat   = (hits.size() > 1) ? hits[1] + 1 : 8;
  endtask

  task automatic accept(input logic [7:0] o, input logic [7:0] r, input logic d);
    int n;
    n = 0;
    while (start_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (start_ready !== 1'b1) $display("FAIL accept_ready: start_ready=%b expected 1", start_ready);
    else passed++;
    orig = o; rot = r; dir = d; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    orig = 8'($urandom); rot = 8'($urandom); dir = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [7:0] o, input logic [7:0] r,
                               input logic d);
    int ea, ef, em, el, lat;
    model(o, r, d, ea, ef, em, el);
    accept(o, r, d);
    wait_done(lat);
    total++;
    if (lat !== el) $display("FAIL %s latency: got %0d expected %0d", name, lat, el); else passed++;
    total++;
    if (int'(amt) !== ea) $display("FAIL %s amt: got %0d expected %0d", name, amt, ea); else passed++;
    total++;
    if (int'(found) !== ef) $display("FAIL %s found: got %0d expected %0d", name, found, ef); else passed++;
    total++;
    if (int'(multi) !== em) $display("FAIL %s multi: got %0d expected %0d", name, multi, em); else passed++;
    consume();
  endtask

  task automatic test_reset();
    total++;
    if ({start_ready, done_valid, amt, found, multi} !== 7'b1_0_000_0_0)
      $display("FAIL reset_state: got sr=%b dv=%b amt=%0d f=%b m=%b expected 1 0 0 0 0",
               start_ready, done_valid, amt, found, multi);
    else passed++;
  endtask

  task automatic test_plan();
    run_and_check("plan_right3", 8'b11010010, 8'b01011010, 1'b0);
    run_and_check("plan_left5",  8'b11010010, 8'b01011010, 1'b1);
    run_and_check("plan_period", 8'b10101010, 8'b01010101, 1'b0);
    run_and_check("plan_zero",   8'h00,       8'h00,       1'b0);
  endtask

  task automatic test_hold();
    int lat;
    logic [4:0] snap;
    accept(8'b11010010, 8'hFF, 1'b0);
    wait_done(lat);
    total++;
    if (lat !== 8) $display("FAIL hold_latency: got %0d expected 8", lat); else passed++;
    total++;
    if ({amt, found, multi} !== 5'b000_0_0)
      $display("FAIL hold_result: got amt=%0d f=%b m=%b expected 0 0 0", amt, found, multi);
    else passed++;
    snap = {amt, found, multi};
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1; orig = 8'($urandom); rot = orig; dir = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if ({done_valid, start_ready, amt, found, multi} !== {1'b1, 1'b0, snap})
        $display("FAIL hold_stable cycle %0d: got dv=%b sr=%b amt=%0d f=%b m=%b expected 1 0 %0d %b %b",
                 i, done_valid, start_ready, amt, found, multi, snap[4:2], snap[1], snap[0]);
      else passed++;
    end
    start_valid = 1'b0;
    consume();
    total++;
    if ({start_ready, done_valid} !== 2'b10)
      $display("FAIL hold_release: got sr=%b dv=%b expected 1 0", start_ready, done_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_search();
    int lat;
    accept(8'b11010010, 8'b01011010, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({start_ready, done_valid, amt, found, multi} !== 7'b1_0_000_0_0)
      $display("FAIL midreset_state: got sr=%b dv=%b amt=%0d f=%b m=%b expected 1 0 0 0 0",
               start_ready, done_valid, amt, found, multi);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done(lat);
    total++;
    if (done_valid !== 1'b0) $display("FAIL midreset_no_result: done_valid=%b expected 0", done_valid);
    else passed++;
    run_and_check("after_reset", 8'b11010010, 8'b11010010, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] o, r;
    logic d;
    for (int it = 0; it < 40; it++) begin
      d = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin o = 8'($urandom); r = 8'($urandom); end
        1: begin o = 8'($urandom); r = rot_ref(o, $urandom_range(0, 7), 1'($urandom)); end
        2: begin o = {4{2'($urandom)}}; r = rot_ref(o, $urandom_range(0, 7), d); end
        default: begin o = {2{4'($urandom)}}; r = rot_ref(o, $urandom_range(0, 7), d); end
      endcase
      run_and_check($sformatf("rand%0d", it), o, r, d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_back_to_back();
    int ea, ef, em, el, lat;
    logic [7:0] o;
    done_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      o = 8'($urandom);
      model(o, rot_ref(o, it, 1'b1), 1'b1, ea, ef, em, el);
      accept(o, rot_ref(o, it, 1'b1), 1'b1);
      done_ready = 1'b1;
      wait_done(lat);
      total++;
      if (lat !== el || int'(amt) !== ea || int'(found) !== ef || int'(multi) !== em)
        $display("FAIL b2b%0d: got lat=%0d amt=%0d f=%b m=%b expected %0d %0d %0d %0d",
                 it, lat, amt, found, multi, el, ea, ef, em);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({start_ready, done_valid} !== 2'b10)
        $display("FAIL b2b%0d_turn: got sr=%b dv=%b expected 1 0", it, start_ready, done_valid);
      else passed++;
    end
    done_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    orig = 8'h00; rot = 8'h00; dir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_plan();
    test_hold();
    test_reset_mid_search();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rotate_amount_finder.md
# rotate_amount_finder

Sequential inverse of the team's parameterized barrel shifter. Given an original word, a rotated word and a rotation direction, it finds the rotate amount that maps one onto the other. It tests one candidate amount per clock and reports the result through a valid/ready result handshake. It sits beside the shifter as its checker and decoder, for example to recover the shift amount applied upstream.

## Interface
- N, default 3: amount width; data width W = 2**N.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start_valid  input  1  request present.
- start_ready  output  1  block idle; request accepted on start_valid & start_ready.
- orig  input  W  unrotated word, sampled at acceptance.
- rot  input  W  rotated word, sampled at acceptance.
- dir  input  1  0 = rot is a right rotation of orig, 1 = left; sampled at acceptance.
- done_valid  output  1  result valid.
- done_ready  input  1  result consumed on done_valid & done_ready.
- amt  output  N  smallest matching rotate amount (0 when found=0).
- found  output  1  at least one amount matches.
- multi  output  1  a second, larger amount also matches (periodic pattern).

## Operation
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - start_ready=1.
  - On acceptance, register orig into work, rot into target, dir into dir_q. Clear cand, amt, found and multi. Go to SEARCH.
  - orig, rot and dir are ignored outside acceptance.
- SEARCH: each cycle compare work == target for candidate cand.
  - On the first match: amt<=cand, found<=1.
  - On a match while found=1: multi<=1, go to DONE. This is an early exit.
  - Otherwise, if cand == W-1, go to DONE. If not, rotate work by one position in dir_q and set cand<=cand+1.
  - cand is N bits; the terminal test on W-1 prevents wrap-around.
- DONE: done_valid=1. amt, found and multi are held stable until done_ready=1, then go to IDLE.
- Outputs are qualified by done_valid only. Their values outside DONE are don't-care but deterministic, and are cleared at acceptance.
- start_valid is ignored in SEARCH and DONE (start_ready=0). There is no queuing.
- Rotation semantics match the shifter:
  - Right by k: out[i] = in[(i+k) mod W].
  - Left by k: out[i] = in[(i-k) mod W].
  - Left k and right W-k describe the same word; the answer depends on dir.

## Timing
- Reset (asynchronous, any time): state=IDLE, start_ready=1, done_valid=0, amt=0, found=0, multi=0.
- Reset mid-SEARCH or mid-DONE aborts the request and produces no result.
- start_ready and done_valid are decoded from registered state only, with no combinational path from inputs.
- Acceptance at edge t. The candidate c is evaluated in the cycle after edge t+c.
- If the search stops at candidate c, done_valid rises after edge t+c+1. Latency is c+1 cycles.
  - c = second-match index if multi, else W-1.
  - Worst case is W cycles.
- Result handshake completes at edge u. IDLE follows after u, and start_ready=1 in the next cycle.
- Minimum turnaround is (latency + 1) cycles per request with done_ready tied high.
- done_ready asserted before done_valid has no effect.

## Structure
- Package rotate_pkg:
  - state enum type (IDLE, SEARCH, DONE).
  - localparam DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
  - function rot1(word, dir), single-position rotate, parameterized by width.
- Sub-module rotate_step: combinational one-position rotate, instantiated once on work.
- FSM, cand counter and result registers live in rotate_amount_finder.

## Test plan
- orig=8'b11010010, rot=8'b01011010, dir=0 -> amt=3, found=1, multi=0, done_valid 8 cycles after acceptance.
- Same orig and rot, dir=1 -> amt=5, found=1, multi=0.
- orig=8'b10101010, rot=8'b01010101, dir=0 -> amt=1, found=1, multi=1, done_valid 4 cycles after acceptance (exit at candidate 3).
- orig=rot=8'h00 -> amt=0, found=1, multi=1, latency 2.
- orig=8'b11010010, rot=8'hFF -> found=0, amt=0, multi=0, latency 8. Hold done_ready=0 for 5 cycles: outputs stay stable, start_valid is ignored.
- Assert reset during SEARCH at candidate 4 -> all outputs go to reset values immediately, no done_valid. A new request (rot=orig, dir=0) -> amt=0, found=1, multi=0.
